inst_axi_rd_bridge: RTL and testbench

//  Read-only bridge between the fetch stage's SRAM-like instruction port (req/addr_ok/data_ok) and an AXI4 read

---
 rtl/inst_axi_rd_bridge.sv | 167 ++++++++++++++++
 tb/tb_inst_axi_rd_bridge.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_axi_rd_bridge.sv
// Fetch-side SRAM-like read port to AXI4 AR/R bridge with in-order returns; data_ok one cycle after the R handshake.
// addr_ok drops while an AR is pending or MAX_OUTST reads are in flight; R is always accepted while any read is owed.
module inst_axi_rd_bridge #(
  parameter int          MAX_OUTST = 2,
  parameter logic [3:0]  ARID_VAL  = 4'd0
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,

  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,

  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,

  output logic        bus_err,
  output logic        wr_err
);

  typedef enum logic {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

  localparam logic [2:0] LP_MAX_CNT = 3'(MAX_OUTST);

  ar_state_t   r_state;
  ar_state_t   w_state_nxt;
  logic [31:0] r_araddr;
  logic [1:0]  r_arsize;
  logic [2:0]  r_outst_cnt;
  logic        r_data_ok;
  logic [31:0] r_rdata;
  logic        r_bus_err;
  logic        r_wr_err;

  logic        w_addr_ok;
  logic        w_arvalid;
  logic        w_ar_hs;
  logic        w_r_hs;
  logic        w_rready;
  logic        w_unused;

  // Write-side inputs and the R id/last are deliberately ignored: single id, single-beat bursts.
  assign w_unused = ^{inst_sram_wstrb, inst_sram_wdata, rid, rlast};

  always_comb begin
    w_state_nxt = r_state;
    w_addr_ok   = 1'b0;
    w_arvalid   = 1'b0;
    case (r_state)
      AR_IDLE: begin
        w_addr_ok = inst_sram_req && (r_outst_cnt < LP_MAX_CNT);
        if (w_addr_ok) begin
          w_state_nxt = AR_SEND;
        end
      end
      AR_SEND: begin
        w_arvalid = 1'b1;
        if (arready) begin
          w_state_nxt = AR_IDLE;
        end
      end
      default: begin
        w_state_nxt = AR_IDLE;
      end
    endcase
  end

  assign w_ar_hs  = w_arvalid && arready;
  assign w_rready = (r_outst_cnt != 3'd0);
  assign w_r_hs   = rvalid && w_rready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= AR_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_araddr <= 32'd0;
      r_arsize <= 2'd0;
    end else if (w_addr_ok) begin
      r_araddr <= inst_sram_addr;
      r_arsize <= inst_sram_size;
    end
  end

  // Full check sees only this cycle's count; a same-cycle return frees a slot next cycle.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_outst_cnt <= 3'd0;
    end else begin
      case ({w_addr_ok, w_r_hs})
        2'b10:   r_outst_cnt <= r_outst_cnt + 3'd1;
        2'b01:   r_outst_cnt <= r_outst_cnt - 3'd1;
        default: r_outst_cnt <= r_outst_cnt;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_data_ok <= 1'b0;
      r_bus_err <= 1'b0;
      r_rdata   <= 32'd0;
    end else begin
      r_data_ok <= w_r_hs;
      r_bus_err <= w_r_hs && (rresp != 2'b00);
      if (w_r_hs) begin
        r_rdata <= rdata;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_err <= 1'b0;
    end else if (w_addr_ok && inst_sram_wr) begin
      r_wr_err <= 1'b1;
    end
  end

  assign inst_sram_addr_ok = w_addr_ok;
  assign inst_sram_data_ok = r_data_ok;
  assign inst_sram_rdata   = r_rdata;

  assign arid    = ARID_VAL;
  assign araddr  = r_araddr;
  assign arlen   = 8'd0;
  assign arsize  = {1'b0, r_arsize};
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign arvalid = w_arvalid;

  assign rready  = w_rready;
  assign bus_err = r_bus_err;
  assign wr_err  = r_wr_err;

endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// Directed bench for inst_axi_rd_bridge: per-cycle vector table plus hand sequences for stall, credit limit and reset.
module tb_inst_axi_rd_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic [3:0]  inst_sram_wstrb;
  logic [31:0] inst_sram_wdata;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic        bus_err;
  logic        wr_err;

  int n_vec = 0;
  int n_err = 0;

  inst_axi_rd_bridge dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_wstrb   (inst_sram_wstrb),
    .inst_sram_wdata   (inst_sram_wdata),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .arid              (arid),
    .araddr            (araddr),
    .arlen             (arlen),
    .arsize            (arsize),
    .arburst           (arburst),
    .arlock            (arlock),
    .arcache           (arcache),
    .arprot            (arprot),
    .arvalid           (arvalid),
    .arready           (arready),
    .rid               (rid),
    .rdata             (rdata),
    .rresp             (rresp),
    .rlast             (rlast),
    .rvalid            (rvalid),
    .rready            (rready),
    .bus_err           (bus_err),
    .wr_err            (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [31:0] addr;
    logic        arready;
    logic        rvalid;
    logic [31:0] rd;
    logic [1:0]  rresp;
    logic        e_addr_ok;
    logic        e_arvalid;
    logic [31:0] e_araddr;
    logic        e_rready;
    logic        e_data_ok;
    logic [31:0] e_rdata;
    logic        e_bus_err;
    logic        e_wr_err;
  } vec_t;

  vec_t vq[$];

  task automatic addv(input logic req, input logic wr, input logic [31:0] addr,
                      input logic ar_rdy, input logic r_vld, input logic [31:0] rd, input logic [1:0] rsp,
                      input logic e_aok, input logic e_arv, input logic [31:0] e_ara, input logic e_rrdy,
                      input logic e_dok, input logic [31:0] e_rdat, input logic e_berr, input logic e_werr);
    vec_t v;
    v.req = req; v.wr = wr; v.size = 2'd2; v.addr = addr;
    v.arready = ar_rdy; v.rvalid = r_vld; v.rd = rd; v.rresp = rsp;
    v.e_addr_ok = e_aok; v.e_arvalid = e_arv; v.e_araddr = e_ara; v.e_rready = e_rrdy;
    v.e_data_ok = e_dok; v.e_rdata = e_rdat; v.e_bus_err = e_berr; v.e_wr_err = e_werr;
    vq.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic req, input logic wr, input logic [1:0] size, input logic [31:0] addr,
                       input logic ar_rdy, input logic r_vld, input logic [31:0] rd, input logic [1:0] rsp);
    inst_sram_req  = req;
    inst_sram_wr   = wr;
    inst_sram_size = size;
    inst_sram_addr = addr;
    arready        = ar_rdy;
    rvalid         = r_vld;
    rdata          = rd;
    rresp          = rsp;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  int n_ok;

  initial begin
    resetn          = 1'b0;
    inst_sram_wstrb = 4'hf;
    inst_sram_wdata = 32'h0;
    rid             = 4'd0;
    rlast           = 1'b1;
    drive(0, 0, 2'd0, 32'h0, 0, 0, 32'h0, 2'b00);

    // Table rows: req wr addr | arready rvalid rdata rresp | addr_ok arvalid araddr rready data_ok rdata bus_err wr_err
    addv(1, 0, 32'h1c000000, 1, 0, 32'h0,        2'b00, 1, 0, 32'h0,        0, 0, 32'h0,        0, 0);
    addv(0, 0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 1, 32'h1c000000, 1, 0, 32'h0,        0, 0);
    addv(0, 0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 32'h0,        1, 0, 32'h0,        0, 0);
    addv(0, 0, 32'h0,        1, 1, 32'h11111111, 2'b00, 0, 0, 32'h0,        1, 0, 32'h0,        0, 0);
    addv(0, 0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 1, 32'h11111111, 0, 0);
    addv(0, 0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 0, 32'h11111111, 0, 0);
    addv(1, 0, 32'h1c000004, 1, 0, 32'h0,        2'b00, 1, 0, 32'h0,        0, 0, 32'h11111111, 0, 0);
    addv(0, 0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 1, 32'h1c000004, 1, 0, 32'h11111111, 0, 0);
    addv(0, 0, 32'h0,        1, 1, 32'hdeadbeef, 2'b10, 0, 0, 32'h0,        1, 0, 32'h11111111, 0, 0);
    addv(0, 0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 1, 32'hdeadbeef, 1, 0);
    addv(0, 0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 0, 32'hdeadbeef, 0, 0);
    addv(1, 1, 32'h1c000008, 1, 0, 32'h0,        2'b00, 1, 0, 32'h0,        0, 0, 32'hdeadbeef, 0, 0);
    addv(0, 0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 1, 32'h1c000008, 1, 0, 32'hdeadbeef, 0, 1);
    addv(0, 0, 32'h0,        1, 1, 32'h22222222, 2'b00, 0, 0, 32'h0,        1, 0, 32'hdeadbeef, 0, 1);
    addv(0, 0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 1, 32'h22222222, 0, 1);
    addv(1, 0, 32'h00000100, 1, 0, 32'h0,        2'b00, 1, 0, 32'h0,        0, 0, 32'h22222222, 0, 1);
    addv(1, 0, 32'h00000104, 1, 0, 32'h0,        2'b00, 0, 1, 32'h00000100, 1, 0, 32'h22222222, 0, 1);
    addv(1, 0, 32'h00000104, 1, 0, 32'h0,        2'b00, 1, 0, 32'h0,        1, 0, 32'h22222222, 0, 1);
    addv(1, 0, 32'h00000108, 1, 0, 32'h0,        2'b00, 0, 1, 32'h00000104, 1, 0, 32'h22222222, 0, 1);
    addv(1, 0, 32'h00000108, 1, 1, 32'ha1a1a1a1, 2'b00, 0, 0, 32'h0,        1, 0, 32'h22222222, 0, 1);
    addv(1, 0, 32'h00000108, 1, 1, 32'ha2a2a2a2, 2'b00, 1, 0, 32'h0,        1, 1, 32'ha1a1a1a1, 0, 1);
    addv(0, 0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 1, 32'h00000108, 1, 1, 32'ha2a2a2a2, 0, 1);
    addv(0, 0, 32'h0,        1, 1, 32'ha3a3a3a3, 2'b00, 0, 0, 32'h0,        1, 0, 32'ha2a2a2a2, 0, 1);
    addv(0, 0, 32'h0,        1, 0, 32'h0,        2'b00, 0, 0, 32'h0,        0, 1, 32'ha3a3a3a3, 0, 1);

    tick();
    tick();
    chk("rst arvalid", 32'(arvalid), 32'd0);
    chk("rst araddr",  araddr,       32'd0);
    chk("rst arsize",  32'(arsize),  32'd0);
    chk("rst rready",  32'(rready),  32'd0);
    chk("rst data_ok", 32'(inst_sram_data_ok), 32'd0);
    chk("rst rdata",   inst_sram_rdata, 32'd0);
    chk("rst bus_err", 32'(bus_err), 32'd0);
    chk("rst wr_err",  32'(wr_err),  32'd0);
    resetn = 1'b1;
    tick();

    for (int i = 0; i < vq.size(); i++) begin
      drive(vq[i].req, vq[i].wr, vq[i].size, vq[i].addr, vq[i].arready, vq[i].rvalid, vq[i].rd, vq[i].rresp);
      chk($sformatf("v%0d addr_ok", i), 32'(inst_sram_addr_ok), 32'(vq[i].e_addr_ok));
      chk($sformatf("v%0d arvalid", i), 32'(arvalid), 32'(vq[i].e_arvalid));
      if (vq[i].e_arvalid) begin
        chk($sformatf("v%0d araddr", i), araddr, vq[i].e_araddr);
        chk($sformatf("v%0d arsize", i), 32'(arsize), 32'd2);
      end
      chk($sformatf("v%0d rready", i),  32'(rready), 32'(vq[i].e_rready));
      chk($sformatf("v%0d data_ok", i), 32'(inst_sram_data_ok), 32'(vq[i].e_data_ok));
      chk($sformatf("v%0d rdata", i),   inst_sram_rdata, vq[i].e_rdata);
      chk($sformatf("v%0d bus_err", i), 32'(bus_err), 32'(vq[i].e_bus_err));
      chk($sformatf("v%0d wr_err", i),  32'(wr_err), 32'(vq[i].e_wr_err));
      tick();
    end

    // AR stall: payload must hold while arready is low, even though req keeps presenting a new address.
    n_ok = 0;
    drive(1, 0, 2'd1, 32'h00002000, 0, 0, 32'h0, 2'b00);
    chk("stall accept", 32'(inst_sram_addr_ok), 32'd1);
    n_ok += int'(inst_sram_addr_ok);
    tick();
    for (int k = 0; k < 4; k++) begin
      drive(1, 0, 2'd0, 32'h00003000, (k == 3), 0, 32'h0, 2'b00);
      chk($sformatf("stall%0d arvalid", k), 32'(arvalid), 32'd1);
      chk($sformatf("stall%0d araddr", k),  araddr, 32'h00002000);
      chk($sformatf("stall%0d arsize", k),  32'(arsize), 32'd1);
      chk($sformatf("stall%0d addr_ok", k), 32'(inst_sram_addr_ok), 32'd0);
      n_ok += int'(inst_sram_addr_ok);
      tick();
    end
    chk("ar constants", {arid, arlen, arburst, arlock, arcache, arprot, 9'd0}, {4'd0, 8'd0, 2'b01, 2'b00, 4'd0, 3'd0, 9'd0});

    // Second read takes the last credit; the third stays blocked until a beat returns.
    drive(1, 0, 2'd0, 32'h00003000, 1, 0, 32'h0, 2'b00);
    chk("2nd accept", 32'(inst_sram_addr_ok), 32'd1);
    n_ok += int'(inst_sram_addr_ok);
    tick();
    drive(1, 0, 2'd2, 32'h00004000, 1, 0, 32'h0, 2'b00);
    chk("2nd araddr", araddr, 32'h00003000);
    chk("2nd arsize", 32'(arsize), 32'd0);
    n_ok += int'(inst_sram_addr_ok);
    tick();
    for (int k = 0; k < 10; k++) begin
      drive(1, 0, 2'd2, 32'h00004000, 1, 0, 32'h0, 2'b00);
      n_ok += int'(inst_sram_addr_ok);
      tick();
    end
    chk("full addr_ok count", 32'(n_ok), 32'd2);
    drive(1, 0, 2'd2, 32'h00004000, 1, 1, 32'hb1b1b1b1, 2'b00);
    chk("no bypass addr_ok", 32'(inst_sram_addr_ok), 32'd0);
    tick();
    drive(1, 0, 2'd2, 32'h00004000, 0, 0, 32'h0, 2'b00);
    chk("3rd accept", 32'(inst_sram_addr_ok), 32'd1);
    chk("b1 data_ok", 32'(inst_sram_data_ok), 32'd1);
    chk("b1 rdata", inst_sram_rdata, 32'hb1b1b1b1);
    tick();

    // Reset with two reads owed and an AR pending.
    drive(0, 0, 2'd0, 32'h0, 0, 0, 32'h0, 2'b00);
    chk("pre-rst arvalid", 32'(arvalid), 32'd1);
    chk("pre-rst araddr", araddr, 32'h00004000);
    resetn = 1'b0;
    tick();
    chk("mid-rst arvalid", 32'(arvalid), 32'd0);
    chk("mid-rst rready",  32'(rready), 32'd0);
    chk("mid-rst data_ok", 32'(inst_sram_data_ok), 32'd0);
    chk("mid-rst wr_err",  32'(wr_err), 32'd0);
    chk("mid-rst araddr",  araddr, 32'd0);
    resetn = 1'b1;
    tick();
    drive(1, 0, 2'd2, 32'h00005000, 1, 0, 32'h0, 2'b00);
    chk("post-rst accept", 32'(inst_sram_addr_ok), 32'd1);
    tick();
    drive(0, 0, 2'd0, 32'h0, 1, 0, 32'h0, 2'b00);
    chk("post-rst arvalid", 32'(arvalid), 32'd1);
    chk("post-rst araddr", araddr, 32'h00005000);
    tick();
    drive(0, 0, 2'd0, 32'h0, 1, 1, 32'hc5c5c5c5, 2'b00);
    chk("post-rst rready", 32'(rready), 32'd1);
    tick();
    drive(0, 0, 2'd0, 32'h0, 1, 0, 32'h0, 2'b00);
    chk("post-rst data_ok", 32'(inst_sram_data_ok), 32'd1);
    chk("post-rst rdata", inst_sram_rdata, 32'hc5c5c5c5);
    chk("post-rst rready idle", 32'(rready), 32'd0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
